// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory port arbiter.
// Holds the FSM state encoding and the streak counter width function.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INST_BUSY = 2'd1,
        DATA_BUSY = 2'd2
    } arb_state_e;

    function automatic int streak_width(input int max_streak);
        return $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: single-outstanding request/ack bus to memory.
// master = arbiter side, slave = memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_streak_ctr.sv
// mem_arb_streak_ctr: saturating count of data grants made while a fetch waits.
// full tells the arbiter the fetch must win the next contested slot.
module mem_arb_streak_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_COUNT = 4,
    parameter int WIDTH     = streak_width(MAX_COUNT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic full
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count;

    assign full = (count == MAX_V);

    // Clear wins over increment; increments stop at the ceiling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !full) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store.
// Data has priority, bounded by a streak limit so fetches cannot starve.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_flush,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_rdata,
    mem_port_arbiter_if.master    mem
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       grant_inst;
    logic       grant_data;
    logic       fetch_ok;
    logic       streak_full;
    logic       drop_q;
    logic       inst_done;
    logic       data_done;

    // A fetch flushed in its request cycle is never granted.
    assign fetch_ok  = inst_req && !inst_flush;
    assign inst_done = (state_q == INST_BUSY) && mem.mem_ack;
    assign data_done = (state_q == DATA_BUSY) && mem.mem_ack;

    mem_arb_streak_ctr #(
        .MAX_COUNT (MAX_DATA_STREAK)
    ) u_streak (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_data && inst_req),
        .clr   (grant_inst),
        .full  (streak_full)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant decision and next state; grants only leave IDLE.
    always_comb begin
        state_d    = state_q;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (data_req && !(fetch_ok && streak_full)) begin
                    grant_data = 1'b1;
                    state_d    = DATA_BUSY;
                end else if (fetch_ok) begin
                    grant_inst = 1'b1;
                    state_d    = INST_BUSY;
                end
            end
            INST_BUSY, DATA_BUSY: begin
                if (mem.mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Remember a redirect seen while the fetch is still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
        end else if (state_q != INST_BUSY || mem.mem_ack) begin
            drop_q <= 1'b0;
        end else if (inst_flush) begin
            drop_q <= 1'b1;
        end
    end

    // Latch the granted request onto the bus and return completions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            inst_valid    <= 1'b0;
            inst_rdata    <= '0;
            data_valid    <= 1'b0;
            data_rdata    <= '0;
        end else begin
            inst_valid <= 1'b0;
            data_valid <= 1'b0;
            if (grant_data) begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= data_we;
                mem.mem_addr  <= data_addr;
                mem.mem_wdata <= data_wdata;
            end else if (grant_inst) begin
                mem.mem_req  <= 1'b1;
                mem.mem_we   <= 1'b0;
                mem.mem_addr <= inst_addr;
            end else if (inst_done || data_done) begin
                mem.mem_req <= 1'b0;
            end
            if (inst_done && !drop_q && !inst_flush) begin
                inst_valid <= 1'b1;
                inst_rdata <= mem.mem_rdata;
            end
            if (data_done) begin
                data_valid <= 1'b1;
                if (!mem.mem_we) begin
                    data_rdata <= mem.mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic against
// a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_flush;
    logic          inst_valid;
    logic [DW-1:0] inst_rdata;
    logic          data_req;
    logic          data_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_valid;
    logic [DW-1:0] data_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    mem_port_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_DATA_STREAK (MAXS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_flush (inst_flush),
        .inst_valid (inst_valid),
        .inst_rdata (inst_rdata),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_valid (data_valid),
        .data_rdata (data_rdata),
        .mem        (mem_if)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: one outstanding transaction, who owns it, streak
    bit            m_busy;
    bit            m_inst;
    bit            m_drop;
    bit            m_we;
    int            m_streak;
    logic          exp_req;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic          exp_ival;
    logic          exp_dval;
    logic [DW-1:0] exp_irdata;
    logic [DW-1:0] exp_drdata;

    // stimulus control
    bit            rand_mode;
    bit            reraise;
    bit            mem_manual;
    bit            wait_rand;
    bit            rdata_rand;
    int            wait_fixed;
    int            mem_wait;
    logic [DW-1:0] fixed_rdata;
    int            n_ival;
    int            n_dval;
    int            data_seq;
    logic          prev_req;
    logic [AW-1:0] grant_addrs[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Apply the arbitration rules to this cycle's inputs; result is what
    // the registered outputs must show after the coming edge.
    task automatic model_edge();
        bit fetch_ok;
        exp_ival = 1'b0;
        exp_dval = 1'b0;
        if (!rst_n) begin
            m_busy     = 1'b0;
            m_drop     = 1'b0;
            m_streak   = 0;
            exp_req    = 1'b0;
            exp_we     = 1'b0;
            exp_addr   = '0;
            exp_wdata  = '0;
            exp_irdata = '0;
            exp_drdata = '0;
            return;
        end
        if (m_busy) begin
            if (mem_if.mem_ack) begin
                if (m_inst) begin
                    if (!m_drop && !inst_flush) begin
                        exp_ival   = 1'b1;
                        exp_irdata = mem_if.mem_rdata;
                    end
                end else begin
                    exp_dval = 1'b1;
                    if (!m_we) exp_drdata = mem_if.mem_rdata;
                end
                m_busy  = 1'b0;
                m_drop  = 1'b0;
                exp_req = 1'b0;
            end else if (m_inst && inst_flush) begin
                m_drop = 1'b1;
            end
            return;
        end
        fetch_ok = inst_req && !inst_flush;
        if (data_req && !(fetch_ok && m_streak == MAXS)) begin
            m_busy    = 1'b1;
            m_inst    = 1'b0;
            m_we      = data_we;
            exp_req   = 1'b1;
            exp_we    = data_we;
            exp_addr  = data_addr;
            exp_wdata = data_wdata;
            if (inst_req && m_streak < MAXS) m_streak++;
            mem_wait = wait_rand ? int'($urandom_range(0, 3)) : wait_fixed;
        end else if (fetch_ok) begin
            m_busy   = 1'b1;
            m_inst   = 1'b1;
            exp_req  = 1'b1;
            exp_we   = 1'b0;
            exp_addr = inst_addr;
            m_streak = 0;
            mem_wait = wait_rand ? int'($urandom_range(0, 3)) : wait_fixed;
        end
    endtask

    task automatic mem_drive();
        mem_if.mem_rdata = rdata_rand ? $urandom : fixed_rdata;
        if (m_busy) begin
            if (mem_wait == 0) begin
                mem_if.mem_ack = 1'b1;
            end else begin
                mem_if.mem_ack = 1'b0;
                mem_wait--;
            end
        end else begin
            mem_if.mem_ack = rand_mode && ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("mem_req", mem_if.mem_req, exp_req);
        check("inst_valid", inst_valid, exp_ival);
        check("data_valid", data_valid, exp_dval);
        check("inst_rdata", inst_rdata, exp_irdata);
        check("data_rdata", data_rdata, exp_drdata);
        if (exp_req) begin
            check("mem_we", mem_if.mem_we, exp_we);
            check("mem_addr", mem_if.mem_addr, exp_addr);
            if (exp_we) check("mem_wdata", mem_if.mem_wdata, exp_wdata);
        end
        if (mem_if.mem_req && !prev_req) grant_addrs.push_back(mem_if.mem_addr);
        prev_req = mem_if.mem_req;
        if (inst_valid) n_ival++;
        if (data_valid) n_dval++;
    endtask

    task automatic new_data(input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd);
        data_req   = 1'b1;
        data_we    = we;
        data_addr  = a;
        data_wdata = wd;
    endtask

    task automatic cycle();
        if (inst_valid) inst_req = 1'b0;
        if (data_valid) begin
            if (reraise) begin
                data_seq++;
                new_data(1'b0, 32'h200 + 32'(4 * data_seq), '0);
            end else if (rand_mode && $urandom_range(0, 1) == 1) begin
                new_data(1'($urandom_range(0, 1)), $urandom & ~32'h3, $urandom);
            end else begin
                data_req = 1'b0;
            end
        end
        if (rand_mode) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            inst_flush = 1'b0;
            if ($urandom_range(0, 15) == 0) begin
                inst_flush = 1'b1;
                inst_req   = 1'($urandom_range(0, 1));
                inst_addr  = $urandom & ~32'h3;
            end else if (!inst_req && $urandom_range(0, 3) == 0) begin
                inst_req  = 1'b1;
                inst_addr = $urandom & ~32'h3;
            end
            if (!data_req && $urandom_range(0, 3) == 0)
                new_data(1'($urandom_range(0, 1)), $urandom & ~32'h3, $urandom);
            if (!rst_n) begin
                inst_req   = 1'b0;
                data_req   = 1'b0;
                inst_flush = 1'b0;
            end
        end
        if (!mem_manual) mem_drive();
        step();
    endtask

    task automatic drain();
        int n = 0;
        while ((m_busy || inst_req || data_req) && n < 50) begin
            cycle();
            n++;
        end
        check("drain_idle", {m_busy, inst_req, data_req}, 0);
    endtask

    initial begin
        int            lat;
        int            dv_cyc;
        int            fr_cyc;
        logic [DW-1:0] prev_rd;
        logic [AW-1:0] seq [5];

        rst_n      = 1'b0;
        inst_req   = 1'b0;
        inst_addr  = '0;
        inst_flush = 1'b0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = '0;
        data_wdata = '0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;
        rand_mode  = 1'b0;
        reraise    = 1'b0;
        mem_manual = 1'b0;
        wait_rand  = 1'b0;
        rdata_rand = 1'b1;
        wait_fixed = 0;
        fixed_rdata = '0;
        prev_req   = 1'b0;
        data_seq   = 0;
        #1;

        cycle();
        cycle();
        check("rst_mem_addr", mem_if.mem_addr, 0);
        check("rst_mem_we", mem_if.mem_we, 0);
        check("rst_mem_wdata", mem_if.mem_wdata, 0);
        check("rst_state", dut.state_q, IDLE);
        check("rst_streak", dut.u_streak.count, 0);
        rst_n = 1'b1;

        // single fetch, memory answers one cycle after mem_req rises
        wait_fixed  = 1;
        rdata_rand  = 1'b0;
        fixed_rdata = 32'hDEADBEEF;
        inst_addr   = 32'h100;
        inst_req    = 1'b1;
        n_ival      = 0;
        lat         = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (n_ival == 1 && lat == 0) lat = i + 1;
        end
        check("fetch_latency", lat, 3);
        check("fetch_pulses", n_ival, 1);
        check("fetch_rdata", inst_rdata, 32'hDEADBEEF);

        // simultaneous requests: data first, fetch right after data_valid
        wait_fixed = 0;
        rdata_rand = 1'b1;
        grant_addrs.delete();
        inst_addr = 32'h180;
        inst_req  = 1'b1;
        new_data(1'b0, 32'h200, '0);
        dv_cyc = -1;
        fr_cyc = -1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (data_valid && dv_cyc < 0) dv_cyc = i;
            if (mem_if.mem_req && mem_if.mem_addr == 32'h180 && fr_cyc < 0)
                fr_cyc = i;
        end
        check("both_grants", grant_addrs.size(), 2);
        check("both_first", grant_addrs[0], 32'h200);
        check("both_fetch_slot", fr_cyc, dv_cyc + 1);
        drain();

        // streak limit with back-to-back data and a waiting fetch
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        grant_addrs.delete();
        data_seq = 0;
        reraise  = 1'b1;
        inst_addr = 32'h100;
        inst_req  = 1'b1;
        new_data(1'b0, 32'h200, '0);
        for (int i = 0; i < 40 && grant_addrs.size() < 5; i++) cycle();
        reraise = 1'b0;
        seq = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h100};
        check("streak_grants", grant_addrs.size(), 5);
        for (int k = 0; k < 5; k++) check("streak_order", grant_addrs[k], seq[k]);
        check("streak_clear", dut.u_streak.count, 0);
        drain();

        // flush while the fetch is outstanding
        prev_rd    = inst_rdata;
        n_ival     = 0;
        wait_fixed = 3;
        inst_addr  = 32'h300;
        inst_req   = 1'b1;
        cycle();
        inst_flush = 1'b1;
        inst_req   = 1'b0;
        cycle();
        inst_flush = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        check("flush_no_valid", n_ival, 0);
        check("flush_rdata", inst_rdata, prev_rd);
        check("flush_state", dut.state_q, IDLE);

        // store
        prev_rd    = data_rdata;
        n_dval     = 0;
        wait_fixed = 2;
        new_data(1'b1, 32'h40, 32'h1234);
        cycle();
        check("store_we", mem_if.mem_we, 1);
        check("store_wdata", mem_if.mem_wdata, 32'h1234);
        for (int i = 0; i < 6; i++) cycle();
        check("store_pulses", n_dval, 1);
        check("store_rdata", data_rdata, prev_rd);
        drain();

        // reset during a load, late ack afterwards
        n_dval     = 0;
        wait_fixed = 5;
        new_data(1'b0, 32'h80, '0);
        cycle();
        cycle();
        rst_n    = 1'b0;
        data_req = 1'b0;
        cycle();
        rst_n      = 1'b1;
        mem_manual = 1'b1;
        mem_if.mem_ack = 1'b0;
        cycle();
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 32'hCAFE;
        cycle();
        mem_if.mem_ack = 1'b0;
        cycle();
        cycle();
        mem_manual = 1'b0;
        check("rstmid_no_valid", n_dval, 0);
        check("rstmid_mem_req", mem_if.mem_req, 0);
        check("rstmid_mem_addr", mem_if.mem_addr, 0);
        check("rstmid_mem_we", mem_if.mem_we, 0);
        check("rstmid_mem_wdata", mem_if.mem_wdata, 0);
        check("rstmid_inst_rdata", inst_rdata, 0);
        check("rstmid_data_rdata", data_rdata, 0);
        check("rstmid_state", dut.state_q, IDLE);

        // random traffic with random wait states, flushes and resets
        rand_mode = 1'b1;
        wait_rand = 1'b1;
        for (int i = 0; i < 4000; i++) cycle();
        rand_mode  = 1'b0;
        rst_n      = 1'b1;
        inst_flush = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
